// File: rtl/l1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l1_bus_arbiter
// Description : Arbitrates the fetch (i_*) and data (d_*) client ports onto
//               the single unified-L1 port. One transaction is in flight at a
//               time. Request fields are registered toward the cache, and read
//               data returns through a wait/done handshake. A watchdog aborts
//               accesses the cache never acknowledges.
//               Optional macro L1_ARB_DPRIO_EN: fixed data-port priority on a
//               tie instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_wait,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wd,
  input  logic [DATA_W/8-1:0] d_mask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_wait,
  output logic                l1_req,
  output logic                l1_we,
  output logic [ADDR_W-1:0]   l1_addr,
  output logic [DATA_W-1:0]   l1_wd,
  output logic [DATA_W/8-1:0] l1_mask,
  input  logic [DATA_W-1:0]   l1_rdata,
  input  logic                l1_ack,
  output logic                arb_err
);

  localparam int c_MASK_W = DATA_W / 8;
  localparam int c_WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit c_WD_EN  = (TIMEOUT_CYC > 0);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner_d;
  logic                r_l1_we;
  logic [ADDR_W-1:0]   r_l1_addr;
  logic [DATA_W-1:0]   r_l1_wd;
  logic [c_MASK_W-1:0] r_l1_mask;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_arb_err;
  logic [c_WD_W-1:0]   r_wd_cnt;

  logic w_busy;
  logic w_grant;
  logic w_grant_d;
  logic w_timeout;
  logic w_i_done;
  logic w_d_done;

  assign w_busy    = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
  assign w_grant   = (r_state == S_IDLE) && (i_req || d_req);
  // An ack in the final watchdog cycle still completes the access normally.
  assign w_timeout = c_WD_EN && w_busy && !l1_ack && (r_wd_cnt == c_WD_LAST);

`ifdef L1_ARB_DPRIO_EN
  // Data port wins every tie so loads/stores never starve behind fetch.
  assign w_grant_d = d_req;
`else
  logic r_last_d;

  // On a tie, the port that did not win last time is granted.
  assign w_grant_d = d_req && (!i_req || !r_last_d);

  // Remember the last granted port; reset points at D so I wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_d <= 1'b1;
    end else if (w_grant) begin
      r_last_d <= w_grant_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> BUSY_x -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_state_nxt = w_grant_d ? S_BUSY_D : S_BUSY_I;
      S_BUSY_I,
      S_BUSY_D: if (l1_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Capture request fields on grant, response data on completion, and the
  // watchdog count and sticky error flag while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_d <= 1'b0;
      r_l1_we   <= 1'b0;
      r_l1_addr <= '0;
      r_l1_wd   <= '0;
      r_l1_mask <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_arb_err <= 1'b0;
      r_wd_cnt  <= '0;
    end else begin
      if (w_grant) begin
        r_owner_d <= w_grant_d;
        r_l1_we   <= w_grant_d && d_we;
        r_l1_addr <= w_grant_d ? d_addr : i_addr;
        r_l1_wd   <= w_grant_d ? d_wd : '0;
        r_l1_mask <= w_grant_d ? d_mask : '0;
        r_wd_cnt  <= '0;
      end
      if (w_busy) begin
        if (l1_ack) begin
          if (r_owner_d) r_d_rdata <= l1_rdata;
          else           r_i_rdata <= l1_rdata;
        end else if (w_timeout) begin
          if (r_owner_d) r_d_rdata <= '0;
          else           r_i_rdata <= '0;
          r_arb_err <= 1'b1;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end
    end
  end

  // The done pulse lasts exactly the single DONE cycle.
  assign w_i_done = (r_state == S_DONE) && !r_owner_d;
  assign w_d_done = (r_state == S_DONE) && r_owner_d;

  assign i_wait  = i_req && !w_i_done;
  assign d_wait  = d_req && !w_d_done;
  assign l1_req  = w_busy;
  assign l1_we   = r_l1_we;
  assign l1_addr = r_l1_addr;
  assign l1_wd   = r_l1_wd;
  assign l1_mask = r_l1_mask;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign arb_err = r_arb_err;

endmodule
`default_nettype wire

// File: tb/tb_l1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_bus_arbiter
// Description : Self-checking bench for l1_bus_arbiter. A transaction-level
//               reference model schedules grants, acks and completions by
//               cycle number; directed table vectors plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_bus_arbiter;

  localparam int TO = 4;
`ifdef L1_ARB_DPRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, l1_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wd = '0, l1_rdata = '0;
  logic [3:0]  d_mask = '0;
  logic [31:0] i_rdata, d_rdata, l1_addr, l1_wd;
  logic [3:0]  l1_mask;
  logic        i_wait, d_wait, l1_req, l1_we, arb_err;

  always #5 clk = ~clk;

  l1_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_wait(i_wait),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd), .d_mask(d_mask),
    .d_rdata(d_rdata), .d_wait(d_wait),
    .l1_req(l1_req), .l1_we(l1_we), .l1_addr(l1_addr), .l1_wd(l1_wd),
    .l1_mask(l1_mask), .l1_rdata(l1_rdata), .l1_ack(l1_ack), .arb_err(arb_err)
  );

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: one transaction with cycle-numbered milestones.
  bit          m_busy = 0, m_owner_d = 0, m_to = 0, m_err = 0, m_last_d = 1;
  int          m_start = 0, m_ack_cyc = -1, m_done_cyc = 0, m_free = 0;
  logic [31:0] m_addr = '0, m_wd = '0, m_rdata = '0, m_irdata = '0, m_drdata = '0;
  logic        m_we = 0;
  logic [3:0]  m_mask = '0;

  // Stimulus control and observations.
  int          next_delay = -2;     // -2 random 0..2, -1 never ack, else fixed
  bit          use_rdata = 0;
  logic [31:0] next_rdata = '0;
  int          auto_mode = 0;       // 0 manual, 1 random clients, 2 always request
  bit          i_seen = 0, d_seen = 0, prev_l1_req = 0;
  int          obs_done = -1, obs_l1req_cnt = 0, obs_dlow_cnt = 0;
  logic [31:0] obs_addr = '0, obs_rdata = '0;
  logic [31:0] grants[$];

  typedef struct {
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wd, rdata;
    logic [3:0]  d_mask;
    int          delay;
    logic        exp_d;
    int          lat;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive_auto();
    if (!i_req || i_seen) begin
      if (auto_mode == 2) i_req = 1'b1;
      else if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
      else i_req = 1'b0;
    end
    if (!d_req || d_seen) begin
      if (auto_mode == 2) d_req = 1'b1;
      else if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
        d_wd = $urandom; d_mask = 4'($urandom_range(0, 15));
      end else d_req = 1'b0;
    end
  endtask

  // One clock cycle: drive, check against model, advance model.
  task automatic step();
    bit done_now, exp_req, gd;
    int dly;
    @(negedge clk);
    reset = 1'b1;
    cyc++;
    if (auto_mode != 0) drive_auto();
    l1_ack   = m_busy && (cyc == m_ack_cyc);
    l1_rdata = l1_ack ? m_rdata : $urandom;
    #1;
    done_now = m_busy && (cyc == m_done_cyc);
    if (done_now) begin
      if (m_owner_d) m_drdata = m_to ? 32'h0 : m_rdata;
      else           m_irdata = m_to ? 32'h0 : m_rdata;
      if (m_to) m_err = 1'b1;
    end
    exp_req = m_busy && (cyc >= m_start) && (cyc < m_done_cyc);
    chk("l1_req", l1_req, exp_req);
    if (exp_req) begin
      chk("l1_addr", l1_addr, m_addr);
      chk("l1_we", l1_we, m_we);
      chk("l1_mask", l1_mask, m_mask);
      if (m_owner_d) chk("l1_wd", l1_wd, m_wd);
    end
    chk("i_wait", i_wait, i_req && !(done_now && !m_owner_d));
    chk("d_wait", d_wait, d_req && !(done_now && m_owner_d));
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("arb_err", arb_err, m_err);
    // observations
    if (l1_req && !prev_l1_req) begin obs_addr = l1_addr; grants.push_back(l1_addr); end
    prev_l1_req = l1_req;
    if (l1_req) obs_l1req_cnt++;
    if (d_req && !d_wait) obs_dlow_cnt++;
    i_seen = i_req && !i_wait;
    d_seen = d_req && !d_wait;
    if (i_seen) begin obs_done = 0; obs_rdata = i_rdata; end
    if (d_seen) begin obs_done = 1; obs_rdata = d_rdata; end
    // model advance
    if (done_now) begin m_busy = 0; m_free = cyc + 1; end
    if (!m_busy && cyc >= m_free && (i_req || d_req)) begin
      if (i_req && d_req) gd = PRIO ? 1'b1 : !m_last_d;
      else gd = d_req;
      m_last_d = gd; m_owner_d = gd; m_busy = 1; m_start = cyc + 1;
      m_addr = gd ? d_addr : i_addr;
      m_we   = gd ? d_we : 1'b0;
      m_mask = gd ? d_mask : 4'h0;
      m_wd   = d_wd;
      dly = (next_delay == -2) ? $urandom_range(0, 2) : next_delay;
      if (dly < 0) begin m_to = 1; m_ack_cyc = -1; m_done_cyc = m_start + TO; end
      else begin m_to = 0; m_ack_cyc = m_start + dly; m_done_cyc = m_ack_cyc + 1; end
      m_rdata = use_rdata ? next_rdata : $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted away from the clock edge and checked immediately.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0; l1_ack = 1'b0;
    #1;
    chk("rst_l1_req", l1_req, 1'b0);
    chk("rst_arb_err", arb_err, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_l1_addr", l1_addr, 32'h0);
    chk("rst_l1_we", l1_we, 1'b0);
    chk("rst_l1_mask", l1_mask, 4'h0);
    chk("rst_i_wait", i_wait, i_req);
    repeat (n - 1) @(negedge clk);
    m_busy = 0; m_last_d = 1; m_irdata = '0; m_drdata = '0; m_err = 0;
    m_free = cyc + 1; i_seen = 0; d_seen = 0; prev_l1_req = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{i_req:1, d_req:0, d_we:0, i_addr:32'h100, d_addr:32'h0, d_wd:32'h0,
               rdata:32'h00500093, d_mask:4'h0, delay:0, exp_d:0, lat:3};
    tbl[1] = '{i_req:0, d_req:1, d_we:1, i_addr:32'h0, d_addr:32'h2004, d_wd:32'hCAFEBABE,
               rdata:32'h11111111, d_mask:4'b0011, delay:2, exp_d:1, lat:5};
    tbl[2] = '{i_req:1, d_req:1, d_we:0, i_addr:32'h200, d_addr:32'h3000, d_wd:32'h0,
               rdata:32'h22222222, d_mask:4'hF, delay:1, exp_d:PRIO, lat:4};
    tbl[3] = '{i_req:1, d_req:1, d_we:1, i_addr:32'h204, d_addr:32'h3004, d_wd:32'h55AA55AA,
               rdata:32'h33333333, d_mask:4'b1100, delay:0, exp_d:1, lat:3};
    tbl[4] = '{i_req:0, d_req:1, d_we:0, i_addr:32'h0, d_addr:32'h3008, d_wd:32'h0,
               rdata:32'h44444444, d_mask:4'hF, delay:0, exp_d:1, lat:3};
    tbl[5] = '{i_req:1, d_req:1, d_we:0, i_addr:32'h208, d_addr:32'h300C, d_wd:32'h0,
               rdata:32'h55555555, d_mask:4'hF, delay:2, exp_d:PRIO, lat:5};
    tbl[6] = '{i_req:1, d_req:0, d_we:0, i_addr:32'h20C, d_addr:32'h0, d_wd:32'h0,
               rdata:32'h66666666, d_mask:4'h0, delay:1, exp_d:0, lat:4};

    // Reset held with a fetch pending.
    i_req = 1'b1; i_addr = 32'h100;
    do_reset(3);

    // Directed vectors, each from an idle arbiter.
    foreach (tbl[k]) begin
      i_req = tbl[k].i_req; i_addr = tbl[k].i_addr;
      d_req = tbl[k].d_req; d_we = tbl[k].d_we; d_addr = tbl[k].d_addr;
      d_wd = tbl[k].d_wd; d_mask = tbl[k].d_mask;
      next_delay = tbl[k].delay; use_rdata = 1; next_rdata = tbl[k].rdata;
      obs_done = -1; n = 0;
      while (obs_done < 0 && n < 20) begin step(); n++; end
      chk("tbl_latency", n, tbl[k].lat);
      chk("tbl_grant_addr", obs_addr, tbl[k].exp_d ? tbl[k].d_addr : tbl[k].i_addr);
      chk("tbl_done_port", obs_done, tbl[k].exp_d);
      chk("tbl_rdata", obs_rdata, tbl[k].rdata);
      i_req = 0; d_req = 0;
      step();
    end
    use_rdata = 0;

    // Both ports requesting continuously from reset.
    do_reset(2);
    i_addr = 32'h40; d_addr = 32'h80; d_we = 0; d_mask = 4'hF;
    i_req = 1; d_req = 1; next_delay = -2; auto_mode = 2;
    grants.delete();
    n = 0;
    while (grants.size() < 4 && n < 40) begin step(); n++; end
    auto_mode = 0;
    chk("alt_budget", grants.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk("alt_grant_is_d", grants[k] == 32'h80, PRIO ? 1'b1 : 1'(k % 2));
    i_req = 0; d_req = 0;
    repeat (6) step();

    // Data client abandons its request once the access is issued.
    d_req = 1; d_we = 1; d_addr = 32'h4000; d_wd = 32'hA5A5F00F; d_mask = 4'b0110;
    next_delay = 2;
    step();
    d_req = 0;
    repeat (5) step();
    i_req = 1; i_addr = 32'h500; next_delay = 0; obs_done = -1; n = 0;
    while (obs_done < 0 && n < 20) begin step(); n++; end
    chk("drop_next_i_addr", obs_addr, 32'h500);
    chk("drop_next_i_port", obs_done, 0);
    i_req = 0;
    step();

    // Reset mid-transaction drops l1_req at once.
    i_req = 1; i_addr = 32'h700; next_delay = 2;
    step(); step();
    i_req = 0;
    do_reset(2);
    repeat (3) step();

    // Random traffic.
    next_delay = -2; auto_mode = 1;
    repeat (400) step();
    auto_mode = 0; i_req = 0; d_req = 0;
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end
    step();

    // Watchdog: the cache never acknowledges.
    d_req = 1; d_we = 0; d_addr = 32'h6000; d_mask = 4'hF; next_delay = -1;
    obs_l1req_cnt = 0; obs_dlow_cnt = 0;
    repeat (10) begin
      step();
      if (d_seen) d_req = 0;
    end
    chk("wd_l1req_cycles", obs_l1req_cnt, TO);
    chk("wd_dwait_low_cycles", obs_dlow_cnt, 1);
    chk("wd_arb_err", arb_err, 1'b1);
    chk("wd_d_rdata", d_rdata, 32'h0);
    do_reset(2);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
